// File: rtl/riscv_dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dmem_wb_bridge
// Description : Single-outstanding LSU-to-Wishbone-classic bridge.
//               Flush/invalidate are acknowledged locally.
//               Optional bus timeout via DMEM_BUS_TIMEOUT_EN.
// Revision    : 1.1
// ============================================================================

module riscv_dmem_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic        mem_cacheable_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_invalidate_i,
    input  logic        mem_flush_i,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [10:0] mem_resp_tag_o,
    output logic [31:0] mem_data_rd_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]  r_state, w_state;
    logic [10:0] r_tag, w_tag;
    logic [29:0] r_adr, w_adr;
    logic [31:0] r_dat, w_dat;
    logic [3:0]  r_sel, w_sel;
    logic        r_we, w_we;
    logic [31:0] r_rdata, w_rdata;
    logic        r_err, w_err;

    logic w_req_valid;
    logic w_bus_req;
    logic w_unused_inputs;

    assign w_unused_inputs = ^{mem_cacheable_i, mem_addr_i[1:0]};

    assign w_bus_req   = mem_rd_i | (mem_wr_i != 4'h0);
    assign w_req_valid = w_bus_req | mem_flush_i | mem_invalidate_i;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
`endif

    always_comb begin
        w_state = r_state;
        w_tag   = r_tag;
        w_adr   = r_adr;
        w_dat   = r_dat;
        w_sel   = r_sel;
        w_we    = r_we;
        w_rdata = r_rdata;
        w_err   = r_err;
`ifdef DMEM_BUS_TIMEOUT_EN
        w_cnt   = r_cnt;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_valid) begin
                    w_tag   = mem_req_tag_i;
                    w_adr   = mem_addr_i[31:2];
                    w_dat   = mem_data_wr_i;
                    w_we    = (mem_wr_i != 4'h0);
                    w_sel   = (mem_wr_i != 4'h0) ? mem_wr_i : 4'hF;
                    w_rdata = 32'h0;
                    w_err   = 1'b0;
                    w_state = w_bus_req ? c_ST_BUS : c_ST_RESP;
`ifdef DMEM_BUS_TIMEOUT_EN
                    w_cnt   = '0;
`endif
                end
            end
            c_ST_BUS: begin
                if (wb_err_i) begin
                    w_err   = 1'b1;
                    w_rdata = 32'h0;
                    w_state = c_ST_RESP;
                end else if (wb_ack_i) begin
                    w_err   = 1'b0;
                    w_rdata = r_we ? 32'h0 : wb_dat_i;
                    w_state = c_ST_RESP;
                end
`ifdef DMEM_BUS_TIMEOUT_EN
                else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_err   = 1'b1;
                    w_rdata = 32'h0;
                    w_state = c_ST_RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
`endif
            end
            c_ST_RESP: w_state = c_ST_IDLE;
            default:   w_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_tag   <= 11'h0;
            r_adr   <= 30'h0;
            r_dat   <= 32'h0;
            r_sel   <= 4'h0;
            r_we    <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
`ifdef DMEM_BUS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_tag   <= w_tag;
            r_adr   <= w_adr;
            r_dat   <= w_dat;
            r_sel   <= w_sel;
            r_we    <= w_we;
            r_rdata <= w_rdata;
            r_err   <= w_err;
`ifdef DMEM_BUS_TIMEOUT_EN
            r_cnt   <= w_cnt;
`endif
        end
    end

    assign mem_accept_o   = (r_state == c_ST_IDLE);
    assign mem_ack_o      = (r_state == c_ST_RESP);
    assign mem_error_o    = r_err;
    assign mem_resp_tag_o = r_tag;
    assign mem_data_rd_o  = r_rdata;

    assign wb_cyc_o = (r_state == c_ST_BUS);
    assign wb_stb_o = wb_cyc_o;
    assign wb_adr_o = {r_adr, 2'b00};
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_dmem_wb_bridge
// Description : Directed plus randomized bench for riscv_dmem_wb_bridge.
// Revision    : 1.1
// ============================================================================

module tb_riscv_dmem_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0, mem_data_wr = '0, wb_dat_in = '0;
    logic        mem_rd = 1'b0, mem_cacheable = 1'b0, mem_inv = 1'b0, mem_flush = 1'b0;
    logic [3:0]  mem_wr = '0;
    logic [10:0] mem_tag = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    logic        mem_accept, mem_ack, mem_error, wb_we, wb_cyc, wb_stb;
    logic [10:0] resp_tag;
    logic [31:0] data_rd, wb_adr, wb_dat_out;
    logic [3:0]  wb_sel;

    int n_chk  = 0;
    int n_fail = 0;

    logic        nxt_rd = 1'b0, nxt_fl = 1'b0, nxt_inv = 1'b0;
    logic [3:0]  nxt_wr = '0;
    logic [31:0] nxt_addr = '0, nxt_data = '0;
    logic [10:0] nxt_tag = '0;

    always #5 clk = ~clk;

    riscv_dmem_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_addr_i(mem_addr), .mem_data_wr_i(mem_data_wr), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_cacheable_i(mem_cacheable), .mem_req_tag_i(mem_tag),
        .mem_invalidate_i(mem_inv), .mem_flush_i(mem_flush),
        .mem_accept_o(mem_accept), .mem_ack_o(mem_ack), .mem_error_o(mem_error),
        .mem_resp_tag_o(resp_tag), .mem_data_rd_o(data_rd),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_next();
        mem_rd = nxt_rd; mem_wr = nxt_wr; mem_flush = nxt_fl; mem_inv = nxt_inv;
        mem_addr = nxt_addr; mem_data_wr = nxt_data; mem_tag = nxt_tag;
        mem_cacheable = 1'($urandom);
    endtask

    task automatic clear_next();
        nxt_rd = 0; nxt_wr = 0; nxt_fl = 0; nxt_inv = 0; nxt_addr = 0; nxt_data = 0; nxt_tag = 0;
    endtask

    task automatic do_req(input logic rd, input logic [3:0] wr, input logic fl, input logic inv,
                          input logic [31:0] addr, input logic [31:0] data, input logic [10:0] tag,
                          input int waits, input logic t_ack, input logic t_err,
                          input logic [31:0] rdat);
        logic        is_bus, is_wr, exp_err;
        logic [31:0] exp_data;
        is_bus   = rd | (wr != 0);
        is_wr    = (wr != 0);
        exp_err  = is_bus & t_err;
        exp_data = (!is_bus || is_wr || t_err) ? 32'h0 : rdat;
        mem_rd = rd; mem_wr = wr; mem_flush = fl; mem_inv = inv;
        mem_addr = addr; mem_data_wr = data; mem_tag = tag;
        chk("accept_idle", mem_accept, 1);
        step();
        drive_next();
        if (is_bus) begin
            for (int i = 0; i <= waits; i++) begin
                chk("cyc", wb_cyc, 1);
                chk("stb", wb_stb, 1);
                chk("adr", wb_adr, addr & 32'hFFFF_FFFC);
                chk("sel", wb_sel, is_wr ? wr : 4'hF);
                chk("we", wb_we, is_wr);
                chk("dat_o", wb_dat_out, data);
                chk("ack_during_bus", mem_ack, 0);
                chk("accept_busy", mem_accept, 0);
                wb_dat_in = (i == waits) ? rdat : $urandom;
                wb_ack    = (i == waits) ? t_ack : 1'b0;
                wb_err    = (i == waits) ? t_err : 1'b0;
                step();
            end
            wb_ack = 0; wb_err = 0; wb_dat_in = $urandom;
        end
        chk("resp_ack", mem_ack, 1);
        chk("resp_tag", resp_tag, tag);
        chk("resp_data", data_rd, exp_data);
        chk("resp_err", mem_error, exp_err);
        chk("cyc_after", wb_cyc, 0);
        chk("stb_after", wb_stb, 0);
        chk("accept_resp", mem_accept, 0);
        step();
        chk("ack_one_cycle", mem_ack, 0);
        chk("accept_again", mem_accept, 1);
        chk("cyc_idle", wb_cyc, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_wr;
        logic        r_rd, r_fl, r_inv, r_ack, r_err;
        int          kind, term;

        step(); step();
        chk("rst_accept", mem_accept, 1);
        chk("rst_ack", mem_ack, 0);
        chk("rst_err", mem_error, 0);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_tag", resp_tag, 0);
        chk("rst_data", data_rd, 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat_out, 0);
        chk("rst_sel", wb_sel, 0);
        rst = 0;
        step();

        clear_next();
        do_req(1, 4'h0, 0, 0, 32'h1004, 32'h0, 11'h21F, 0, 1, 0, 32'hDEADBEEF);
        do_req(0, 4'h8, 0, 0, 32'h2003, 32'hAB000000, 11'h055, 3, 1, 0, 32'h12345678);
        do_req(1, 4'h0, 0, 0, 32'h3008, 32'h0, 11'h3A1, 1, 1, 1, 32'hCAFEF00D);
        do_req(1, 4'h3, 0, 0, 32'h4000, 32'h0000BEEF, 11'h101, 0, 1, 0, 32'h1111);
        do_req(0, 4'h0, 1, 0, 32'h5000, 32'h0, 11'h7FF, 0, 0, 0, 32'h0);
        do_req(0, 4'h0, 0, 1, 32'h6000, 32'h0, 11'h400, 0, 0, 0, 32'h0);

        nxt_rd = 1; nxt_addr = 32'h7010; nxt_tag = 11'h0B2;
        do_req(1, 4'h0, 0, 0, 32'h7000, 32'h0, 11'h0B1, 2, 1, 0, 32'hA5A5A5A5);
        clear_next();
        do_req(1, 4'h0, 0, 0, 32'h7010, 32'h0, 11'h0B2, 0, 1, 0, 32'h5A5A5A5A);

        mem_rd = 1; mem_addr = 32'h8000; mem_tag = 11'h123;
        step();
        mem_rd = 0;
        chk("rstmid_cyc_before", wb_cyc, 1);
        rst = 1;
        step();
        rst = 0;
        chk("rstmid_cyc", wb_cyc, 0);
        chk("rstmid_ack", mem_ack, 0);
        chk("rstmid_accept", mem_accept, 1);
        wb_ack = 1; wb_dat_in = 32'hFFFF0000;
        step();
        wb_ack = 0;
        chk("stray_ack_ignored", mem_ack, 0);
        chk("stray_cyc", wb_cyc, 0);
        step();
        chk("stray_ack_later", mem_ack, 0);

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 4);
            term = $urandom_range(0, 2);
            r_rd = (kind == 0) || (kind == 2);
            r_wr = (kind == 1 || kind == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            r_fl = (kind == 3) || (kind != 4 && $urandom_range(0, 3) == 0);
            r_inv = (kind == 4);
            r_ack = (term != 1);
            r_err = (term != 0);
            do_req(r_rd, r_wr, r_fl, r_inv, $urandom, $urandom, 11'($urandom),
                   $urandom_range(0, 4), r_ack, r_err, $urandom);
        end

`ifdef DMEM_BUS_TIMEOUT_EN
        mem_rd = 1; mem_addr = 32'h9004; mem_tag = 11'h2AA;
        step();
        mem_rd = 0;
        for (int i = 0; i < 8; i++) begin
            chk("to_cyc", wb_cyc, 1);
            chk("to_no_ack", mem_ack, 0);
            step();
        end
        chk("to_ack", mem_ack, 1);
        chk("to_err", mem_error, 1);
        chk("to_data", data_rd, 0);
        chk("to_tag", resp_tag, 11'h2AA);
        chk("to_cyc_drop", wb_cyc, 0);
        step();
        chk("to_accept", mem_accept, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
